gshare_bpb: RTL and testbench

GSHARE_BPB -- requirements
Module: gshare_bpb

---
 rtl/gshare_bpb.sv | 88 ++++++++
 tb/tb_gshare_bpb.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/gshare_bpb.sv
// Gshare branch predictor: 2^INDEX_W saturating counters indexed by PC XOR global history.
// Define GSHARE_HASH_EN for the hashed index; leave it undefined for plain bimodal indexing.
module gshare_bpb #(
    parameter int INDEX_W = 10,
    parameter int HIST_W  = 10,
    parameter int CTR_W   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               lookup_valid,
    input  logic [INDEX_W-1:0] lookup_pc_idx,
    output logic               pred_taken,
    output logic [HIST_W-1:0]  pred_ghr,
    input  logic               update_valid,
    input  logic [INDEX_W-1:0] update_pc_idx,
    input  logic [HIST_W-1:0]  update_ghr,
    input  logic               update_taken,
    input  logic               update_mispredict
);

    localparam int               DEPTH    = 1 << INDEX_W;
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);

    logic [DEPTH-1:0][CTR_W-1:0] ctr_q;
    logic [HIST_W-1:0]           ghr_q, ghr_d;
    logic [INDEX_W-1:0]          rd_idx, wr_idx;
    logic [CTR_W-1:0]            ctr_rd, ctr_upd;
    logic [HIST_W-1:0]           ghr_shift, ghr_restore;
    logic                        unused_ghr_msb;

`ifdef GSHARE_HASH_EN
    assign rd_idx = lookup_pc_idx ^ INDEX_W'(ghr_q);
    assign wr_idx = update_pc_idx ^ INDEX_W'(update_ghr);
`else
    assign rd_idx = lookup_pc_idx;
    assign wr_idx = update_pc_idx;
`endif

    // Reads see the stored value only: a same-cycle update to this index lands at the edge.
    assign pred_taken = reset & ctr_q[rd_idx][CTR_W-1];
    assign pred_ghr   = ghr_q;

    assign ctr_rd = ctr_q[wr_idx];

    always_comb begin
        ctr_upd = ctr_rd;
        if (update_taken) begin
            if (ctr_rd != CTR_MAX) ctr_upd = ctr_rd + CTR_W'(1);
        end else begin
            if (ctr_rd != '0) ctr_upd = ctr_rd - CTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctr_q <= {DEPTH{CTR_INIT}};
        end else if (update_valid) begin
            ctr_q[wr_idx] <= ctr_upd;
        end
    end

    // The oldest history bit falls off the top on both the speculative shift and the restore.
    generate
        if (HIST_W == 1) begin : g_hist1
            assign ghr_shift   = pred_taken;
            assign ghr_restore = update_taken;
        end else begin : g_histn
            assign ghr_shift   = {ghr_q[HIST_W-2:0], pred_taken};
            assign ghr_restore = {update_ghr[HIST_W-2:0], update_taken};
        end
    endgenerate

    assign unused_ghr_msb = update_ghr[HIST_W-1];

    // Recovery wins over a same-cycle lookup: the lookup was down the wrong path.
    always_comb begin
        ghr_d = ghr_q;
        if (update_valid && update_mispredict) ghr_d = ghr_restore;
        else if (lookup_valid)                 ghr_d = ghr_shift;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ghr_q <= '0;
        else        ghr_q <= ghr_d;
    end

endmodule

// File: tb/tb_gshare_bpb.sv
// Directed-vector bench for gshare_bpb at default parameters.
module tb_gshare_bpb;

    logic       clk;
    logic       reset;
    logic       lookup_valid;
    logic [9:0] lookup_pc_idx;
    logic       pred_taken;
    logic [9:0] pred_ghr;
    logic       update_valid;
    logic [9:0] update_pc_idx;
    logic [9:0] update_ghr;
    logic       update_taken;
    logic       update_mispredict;

    int n_chk  = 0;
    int n_fail = 0;

    gshare_bpb dut (
        .clk               (clk),
        .reset             (reset),
        .lookup_valid      (lookup_valid),
        .lookup_pc_idx     (lookup_pc_idx),
        .pred_taken        (pred_taken),
        .pred_ghr          (pred_ghr),
        .update_valid      (update_valid),
        .update_pc_idx     (update_pc_idx),
        .update_ghr        (update_ghr),
        .update_taken      (update_taken),
        .update_mispredict (update_mispredict)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle's inputs, then stop at the falling edge for sampling.
    task automatic apply(input logic lv, input logic [9:0] lidx, input logic uv,
                         input logic [9:0] uidx, input logic [9:0] ughr,
                         input logic ut, input logic um);
        lookup_valid      = lv;
        lookup_pc_idx     = lidx;
        update_valid      = uv;
        update_pc_idx     = uidx;
        update_ghr        = ughr;
        update_taken      = ut;
        update_mispredict = um;
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [9:0] uidx, input logic [9:0] ughr,
                       input logic ut, input logic um);
        apply(1'b0, 10'h000, 1'b1, uidx, ughr, ut, um);
        tick();
    endtask

    // Hold reset with busy inputs, check outputs, release with idle inputs.
    task automatic do_reset();
        reset = 1'b0;
        apply(1'b1, 10'h040, 1'b1, 10'h040, 10'h3FF, 1'b1, 1'b1);
        chk("rst_hold_pred", 32'(pred_taken), 32'h0);
        chk("rst_hold_ghr",  32'(pred_ghr),   32'h0);
        apply(1'b0, 10'h000, 1'b0, 10'h000, 10'h000, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
    endtask

    initial begin
        reset = 1'b0;
        lookup_valid = 1'b0; lookup_pc_idx = '0;
        update_valid = 1'b0; update_pc_idx = '0; update_ghr = '0;
        update_taken = 1'b0; update_mispredict = 1'b0;
        do_reset();

        // Reset state seen by a lookup
        apply(1'b1, 10'h155, 1'b0, 10'h000, 10'h000, 1'b0, 1'b0);
        chk("rst_pred", 32'(pred_taken), 32'h0);
        chk("rst_ghr",  32'(pred_ghr),   32'h000);
        tick();

        // Training at 0x010: 1 -> 2 -> 3 -> 3 -> 2 -> 1
        upd(10'h010, 10'h000, 1'b1, 1'b0);
        apply(1'b0, 10'h010, 1'b0, 10'h000, 10'h000, 1'b0, 1'b0);
        chk("train_1", 32'(pred_taken), 32'h1);
        tick();
        upd(10'h010, 10'h000, 1'b1, 1'b0);
        upd(10'h010, 10'h000, 1'b1, 1'b0);
        upd(10'h010, 10'h000, 1'b0, 1'b0);
        apply(1'b0, 10'h010, 1'b0, 10'h000, 10'h000, 1'b0, 1'b0);
        chk("train_sat_dn", 32'(pred_taken), 32'h1);
        tick();
        upd(10'h010, 10'h000, 1'b0, 1'b0);
        apply(1'b0, 10'h010, 1'b0, 10'h000, 10'h000, 1'b0, 1'b0);
        chk("train_weak", 32'(pred_taken), 32'h0);
        tick();

        // Saturation at zero, 0x3FF: 1 -> 0 -> 0 -> 0 -> 1 -> 2
        upd(10'h3FF, 10'h000, 1'b0, 1'b0);
        upd(10'h3FF, 10'h000, 1'b0, 1'b0);
        upd(10'h3FF, 10'h000, 1'b0, 1'b0);
        apply(1'b0, 10'h3FF, 1'b0, 10'h000, 10'h000, 1'b0, 1'b0);
        chk("min_zero", 32'(pred_taken), 32'h0);
        tick();
        upd(10'h3FF, 10'h000, 1'b1, 1'b0);
        apply(1'b0, 10'h3FF, 1'b0, 10'h000, 10'h000, 1'b0, 1'b0);
        chk("min_nowrap", 32'(pred_taken), 32'h0);
        tick();
        upd(10'h3FF, 10'h000, 1'b1, 1'b0);
        apply(1'b0, 10'h3FF, 1'b0, 10'h000, 10'h000, 1'b0, 1'b0);
        chk("min_up", 32'(pred_taken), 32'h1);
        tick();

        // Same-index lookup and update: no bypass
        apply(1'b1, 10'h020, 1'b1, 10'h020, 10'h000, 1'b1, 1'b0);
        chk("coll_same", 32'(pred_taken), 32'h0);
        tick();
        apply(1'b1, 10'h020, 1'b0, 10'h000, 10'h000, 1'b0, 1'b0);
        chk("coll_next", 32'(pred_taken), 32'h1);
        tick();

        do_reset();

        // Speculative shift: predictions 0,1,1 -> GHR 0x003
        upd(10'h040, 10'h000, 1'b1, 1'b0);
        upd(10'h040, 10'h000, 1'b1, 1'b0);
        upd(10'h041, 10'h000, 1'b1, 1'b0);
        upd(10'h041, 10'h000, 1'b1, 1'b0);
        apply(1'b1, 10'h155, 1'b0, 10'h000, 10'h000, 1'b0, 1'b0);
        chk("sh0_pred", 32'(pred_taken), 32'h0);
        chk("sh0_ghr",  32'(pred_ghr),   32'h000);
        tick();
        apply(1'b1, 10'h040, 1'b0, 10'h000, 10'h000, 1'b0, 1'b0);
        chk("sh1_pred", 32'(pred_taken), 32'h1);
        chk("sh1_ghr",  32'(pred_ghr),   32'h000);
        tick();
        apply(1'b1, 10'h041, 1'b0, 10'h000, 10'h000, 1'b0, 1'b0);
        chk("sh2_pred", 32'(pred_taken), 32'h1);
        chk("sh2_ghr",  32'(pred_ghr),   32'h001);
        tick();
        // GHR=3: 0x043 reads 0x040 (trained) when hashed, 0x043 (weak) when bimodal
        apply(1'b0, 10'h043, 1'b0, 10'h000, 10'h000, 1'b0, 1'b0);
        chk("sh3_ghr", 32'(pred_ghr), 32'h003);
`ifdef GSHARE_HASH_EN
        chk("hash_rd", 32'(pred_taken), 32'h1);
`else
        chk("hash_rd", 32'(pred_taken), 32'h0);
`endif
        tick();
        // Write index uses update_ghr; lookup 0x002 with GHR 3 must see it
        upd(10'h002, 10'h003, 1'b1, 1'b0);
        upd(10'h002, 10'h003, 1'b1, 1'b0);
        apply(1'b0, 10'h002, 1'b0, 10'h000, 10'h000, 1'b0, 1'b0);
        chk("hash_wr", 32'(pred_taken), 32'h1);
        chk("upd_hold_ghr", 32'(pred_ghr), 32'h003);
        tick();

        // Recovery: restore to 0x0FF, then restore beats a same-cycle lookup
        upd(10'h200, 10'h07F, 1'b1, 1'b1);
        apply(1'b1, 10'h155, 1'b1, 10'h200, 10'h005, 1'b1, 1'b1);
        chk("rec_pre", 32'(pred_ghr), 32'h0FF);
        tick();
        apply(1'b0, 10'h000, 1'b0, 10'h000, 10'h000, 1'b0, 1'b0);
        chk("rec_post", 32'(pred_ghr), 32'h00B);
        tick();
        upd(10'h200, 10'h3FF, 1'b0, 1'b0);
        apply(1'b0, 10'h000, 1'b0, 10'h3FF, 10'h3FF, 1'b0, 1'b1);
        chk("nomis_hold", 32'(pred_ghr), 32'h00B);
        tick();
        apply(1'b0, 10'h000, 1'b0, 10'h000, 10'h000, 1'b0, 1'b0);
        chk("inval_ign", 32'(pred_ghr), 32'h00B);
        tick();
        upd(10'h200, 10'h3FF, 1'b0, 1'b1);
        apply(1'b0, 10'h000, 1'b0, 10'h000, 10'h000, 1'b0, 1'b0);
        chk("rec_trunc", 32'(pred_ghr), 32'h3FE);
        tick();

        // Mid-run reset discards training (0x040 was 3) and history
        do_reset();
        apply(1'b0, 10'h040, 1'b0, 10'h040, 10'h000, 1'b1, 1'b1);
        chk("post_rst_pred", 32'(pred_taken), 32'h0);
        chk("post_rst_ghr",  32'(pred_ghr),   32'h000);
        tick();
        tick();
        apply(1'b0, 10'h040, 1'b0, 10'h000, 10'h000, 1'b0, 1'b0);
        chk("inval_ctr", 32'(pred_taken), 32'h0);
        chk("inval_ghr", 32'(pred_ghr),   32'h000);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
